// File: rtl/div_tick_pwm_pkg.sv
// Shared types and limits for the div_clk-driven PWM block.
package div_tick_pwm_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into clk and emits a registered one-clk pulse per rising edge.
// Pulse appears SYNC_STAGES+1 edges after the input rises.
module edge_sync
  import div_tick_pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int NS = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [NS-1:0] sync_q, sync_d;
  logic [NS-1:0] vld_q, vld_d;
  logic          prev_q, prev_d;
  logic          armed_q, armed_d;
  logic          rise_q, rise_d;

  // The detector only arms after a genuine (non-reset) low sample reaches the last
  // stage, so a level already high at reset release never produces a pulse.
  always_comb begin
    sync_d  = {sync_q[NS-2:0], din};
    vld_d   = {vld_q[NS-2:0], 1'b1};
    prev_d  = sync_q[NS-1];
    armed_d = armed_q | (vld_q[NS-1] & ~sync_q[NS-1]);
    rise_d  = armed_q & sync_q[NS-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/div_tick_pwm.sv
// Tick-driven PWM generator with shadowed period/duty and wrap-aligned reconfiguration.
// tick is SYNC_STAGES+1 clk after div_clk rises; pwm_out follows cnt by one clk.
module div_tick_pwm
  import div_tick_pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             tick,
  output logic             pwm_out,
  output logic             period_done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_duty_q, act_duty_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_duty_q, sh_duty_d;
  logic             load_q, load_d;
  logic             pwm_q, pwm_d;
  logic             pd_q, pd_d;
  logic             tick_w;
  logic             cfg_hs;
  logic             slot_end;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (div_clk),
    .rise (tick_w)
  );

  assign cfg_ready = (state_q != RUN_PEND);
  assign cfg_hs    = cfg_valid & cfg_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    load_d       = 1'b0;
    pd_d         = 1'b0;
    slot_end     = 1'b0;

    if (cfg_hs) begin
      sh_period_d = period;
      sh_duty_d   = duty;
    end
    if (load_q) begin
      act_period_d = sh_period_q;
      act_duty_d   = sh_duty_q;
    end

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      load_d  = cfg_hs || (state_q == RUN_PEND);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          load_d  = cfg_hs;
        end
        RUN, RUN_PEND: begin
          // Ticks are held off for the one cycle a deferred load is landing, so
          // cnt is never advanced against a period that is about to change.
          if (tick_w && !load_q) begin
            if (act_period_q == '0) begin
              slot_end = 1'b1;
            end else if (cnt_q == act_period_q - CNT_W'(1)) begin
              cnt_d    = '0;
              pd_d     = 1'b1;
              slot_end = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (state_q == RUN && cfg_hs) begin
            state_d = RUN_PEND;
          end else if (state_q == RUN_PEND && slot_end) begin
            state_d      = RUN;
            act_period_d = sh_period_q;
            act_duty_d   = sh_duty_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pwm_d = en && (state_q != IDLE) && (act_period_q != '0) && (cnt_q < act_duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      load_q       <= 1'b0;
      pwm_q        <= 1'b0;
      pd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      load_q       <= load_d;
      pwm_q        <= pwm_d;
      pd_q         <= pd_d;
    end
  end

  assign tick        = tick_w;
  assign pwm_out     = pwm_q;
  assign period_done = pd_q;

endmodule
